// File: rtl/remote_rom_bridge.sv
// rtl/remote_rom_bridge.sv - TileLink-UL Get bridge to a byte-FIFO remote ROM; REMOTE_ROM_DENY_EN enables denial of non-Get opcodes
module remote_rom_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_size,
    input  logic [3:0]  a_source,
    input  logic [63:0] a_address,
    input  logic [7:0]  a_mask,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [2:0]  d_size,
    output logic [3:0]  d_source,
    output logic        d_denied,
    output logic [63:0] d_data,
    input  logic        full,
    output logic        wr_en,
    output logic [7:0]  din,
    input  logic        empty,
    output logic        rd_en,
    input  logic [7:0]  dout
);
    typedef enum logic [1:0] {IDLE, CMD, RESP, ACK} state_t;

    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
`ifdef REMOTE_ROM_DENY_EN
    localparam logic [2:0] GET        = 3'd4;
    localparam logic [2:0] ACCESS_ACK = 3'd0;
`endif

    state_t      state;
    logic [63:0] sr;
    logic [2:0]  push_cnt;
    logic [3:0]  pop_cnt;
    logic [2:0]  cap_cnt;
    logic        cap_pending;
    logic        unused_ok;

    // One shift register serves both directions: address bytes leave from the
    // bottom while response bytes enter at the top, so it ends holding the word.
    assign din    = sr[7:0];
    assign d_data = sr;

    // Strobes are qualified by the live flags so a flag rising mid-burst
    // can never cause an overflow or underflow.
    assign wr_en = (state == CMD) && !full && !rst;
    assign rd_en = (state == RESP) && !pop_cnt[3] && !empty && !rst;

`ifdef REMOTE_ROM_DENY_EN
    assign unused_ok = ^a_mask;
`else
    assign unused_ok = ^{a_mask, a_opcode};
    assign d_denied  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_ready     <= 1'b0;
            sr          <= 64'd0;
            push_cnt    <= 3'd0;
            pop_cnt     <= 4'd0;
            cap_cnt     <= 3'd0;
            cap_pending <= 1'b0;
            d_valid     <= 1'b0;
            d_opcode    <= 3'd0;
            d_size      <= 3'd0;
            d_source    <= 4'd0;
`ifdef REMOTE_ROM_DENY_EN
            d_denied    <= 1'b0;
`endif
        end else begin
            cap_pending <= rd_en;
            case (state)
                IDLE: begin
                    if (a_valid && a_ready) begin
                        a_ready  <= 1'b0;
                        d_size   <= a_size;
                        d_source <= a_source;
                        push_cnt <= 3'd0;
                        pop_cnt  <= 4'd0;
                        cap_cnt  <= 3'd0;
`ifdef REMOTE_ROM_DENY_EN
                        if (a_opcode != GET) begin
                            sr       <= 64'd0;
                            d_opcode <= ACCESS_ACK;
                            d_denied <= 1'b1;
                            d_valid  <= 1'b1;
                            state    <= ACK;
                        end else begin
                            sr       <= a_address;
                            d_denied <= 1'b0;
                            state    <= CMD;
                        end
`else
                        sr    <= a_address;
                        state <= CMD;
`endif
                    end else begin
                        a_ready <= 1'b1;
                    end
                end
                CMD: begin
                    if (wr_en) begin
                        sr       <= {8'h00, sr[63:8]};
                        push_cnt <= push_cnt + 3'd1;
                        if (push_cnt == 3'd7) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rd_en) begin
                        pop_cnt <= pop_cnt + 4'd1;
                    end
                    if (cap_pending) begin
                        sr      <= {dout, sr[63:8]};
                        cap_cnt <= cap_cnt + 3'd1;
                        if (cap_cnt == 3'd7) begin
                            d_valid  <= 1'b1;
                            d_opcode <= ACCESS_ACK_DATA;
                            state    <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (d_ready) begin
                        d_valid <= 1'b0;
                        a_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_remote_rom_bridge.sv
// tb/tb_remote_rom_bridge.sv - scoreboard bench for remote_rom_bridge with a loopback FIFO model
module tb_remote_rom_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode, d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic [63:0] d_data;
    logic        full, wr_en, empty, rd_en;
    logic [7:0]  din, dout;

    remote_rom_bridge dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
        .full(full), .wr_en(wr_en), .din(din),
        .empty(empty), .rd_en(rd_en), .dout(dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [63:0] cmd;
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [3:0]  source;
        logic        denied;
        int          bytes;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  resp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          full_pct = 0, empty_pct = 0, ready_pct = 100;
    int          full_hold = 0, ready_block = 0, cyc = 0;
    bit          full_after3 = 0, empty_toggle = 0;
    logic [7:0]  key = 8'h00;
    int          tx_push = 0, tx_pop = 0;
    logic [63:0] tx_cmd = 64'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Remote side: every command byte is echoed (xor key) into the response FIFO.
    logic       s_w, s_r, s_f, s_e, s_rst;
    logic [7:0] s_b;
    initial begin
        full = 1'b0; empty = 1'b1; dout = 8'h00; d_ready = 1'b0;
        forever begin
            @(posedge clk);
            s_w = wr_en; s_r = rd_en; s_f = full; s_e = empty; s_b = din; s_rst = rst;
            #1;
            cyc++;
            if (s_w) begin
                check("push_while_full", s_f, 0);
                if (!s_f) begin
                    resp_q.push_back(s_b ^ key);
                    tx_push++;
                    tx_cmd = {s_b, tx_cmd[63:8]};
                    if (full_after3 && tx_push == 4) begin
                        full_hold   = 5;
                        full_after3 = 0;
                    end
                end
            end
            if (s_r) begin
                check("pop_while_empty", s_e, 0);
                if (resp_q.size() > 0) begin
                    dout = resp_q.pop_front();
                    tx_pop++;
                end
            end
            if (s_rst) begin
                resp_q.delete();
                tx_push = 0; tx_pop = 0; tx_cmd = 64'd0;
            end
            full = (full_hold > 0) || ($urandom_range(99) < full_pct);
            if (full_hold > 0) full_hold--;
            empty = (resp_q.size() == 0) || (empty_toggle && cyc[0]) || ($urandom_range(99) < empty_pct);
            if (ready_block > 0) begin
                d_ready = 1'b0;
                if (d_valid) ready_block--;
            end else begin
                d_ready = ($urandom_range(99) < ready_pct);
            end
        end
    end

    // Monitor: compares each D-channel handshake against the scoreboard.
    logic        hold = 1'b0;
    logic [63:0] hold_data;
    exp_t        got;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (d_valid) check("a_ready_busy", a_ready, 0);
                if (hold) begin
                    check("hold_valid", d_valid, 1);
                    check("hold_data", d_data, hold_data);
                end
                if (d_valid && d_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_response: got data %0h expected no response", d_data);
                    end else begin
                        got = exp_q.pop_front();
                        check("d_data", d_data, got.data);
                        check("d_opcode", d_opcode, got.opcode);
                        check("d_size", d_size, got.size);
                        check("d_source", d_source, got.source);
                        check("d_denied", d_denied, got.denied);
                        check("push_count", tx_push, got.bytes);
                        check("pop_count", tx_pop, got.bytes);
                        if (got.bytes == 8) check("din_order", tx_cmd, got.cmd);
                    end
                    tx_push = 0; tx_pop = 0; tx_cmd = 64'd0;
                    hold = 1'b0;
                end else begin
                    hold      = d_valid;
                    hold_data = d_data;
                end
            end
        end
    end

    task automatic send(input logic [63:0] addr, input logic [3:0] src, input logic [2:0] sz, input logic [2:0] op);
        exp_t e;
        int   n = 0;
        a_address = addr; a_source = src; a_size = sz; a_opcode = op;
        a_mask = 8'($urandom); a_valid = 1'b1;
        forever begin
            @(posedge clk);
            if (a_ready) break;
            n++;
            if (n > 800) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got a_ready 0 for %0d cycles expected 1", n);
                #1 a_valid = 1'b0;
                return;
            end
        end
`ifdef REMOTE_ROM_DENY_EN
        e.denied = (op != 3'd4);
`else
        e.denied = 1'b0;
`endif
        e.data   = e.denied ? 64'd0 : (addr ^ {8{key}});
        e.cmd    = addr;
        e.opcode = e.denied ? 3'd0 : 3'd1;
        e.size   = sz;
        e.source = src;
        e.bytes  = e.denied ? 0 : 8;
        exp_q.push_back(e);
        #1 a_valid = 1'b0;
        a_address = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset();
        check("rst_a_ready", a_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_din", din, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_d_opcode", d_opcode, 0);
        check("rst_d_size", d_size, 0);
        check("rst_d_source", d_source, 0);
        check("rst_d_denied", d_denied, 0);
        check("rst_d_data", d_data, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("a_ready_after_reset", a_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; a_valid = 1'b0; a_opcode = 3'd4; a_size = 3'd0;
        a_source = 4'd0; a_address = 64'd0; a_mask = 8'd0;
        @(posedge clk); #1;
        do_reset();

        send(64'hEFCD_AB89_6745_2301, 4'd3, 3'd3, 3'd4);
        send(64'h0123_4567_89AB_CDEF, 4'd9, 3'd2, 3'd4);
        drain();

        full_after3 = 1;
        send(64'h1122_3344_5566_7788, 4'd5, 3'd3, 3'd4);
        drain();

        empty_toggle = 1;
        send(64'h8877_6655_4433_2211, 4'd6, 3'd1, 3'd4);
        drain();
        empty_toggle = 0;

        ready_block = 10;
        send(64'hDEAD_BEEF_CAFE_F00D, 4'd12, 3'd3, 3'd4);
        drain();

        // Reset pulse once the command bytes are out and the block is collecting.
        send(64'hA5A5_5A5A_0F0F_F0F0, 4'd1, 3'd3, 3'd4);
        for (int n = 0; n < 300 && tx_push < 8; n++) @(negedge clk);
        check("reached_resp", tx_push, 8);
        @(posedge clk); #1;
        do_reset();
        send(64'h0BAD_F00D_1234_5678, 4'd2, 3'd3, 3'd4);
        drain();

`ifdef REMOTE_ROM_DENY_EN
        send(64'h0000_0000_0000_1000, 4'd7, 3'd3, 3'd0);
        send(64'h0000_0000_0000_2000, 4'd8, 3'd3, 3'd4);
        drain();
`endif

        key = 8'hA5; full_pct = 20; empty_pct = 25; ready_pct = 60;
        for (int i = 0; i < 30; i++) begin
            send({$urandom, $urandom}, 4'($urandom), 3'($urandom),
                 ($urandom_range(3) == 0) ? 3'($urandom) : 3'd4);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
